// File: rtl/prefix_adder_arbiter.sv
// Round-robin arbiter sharing one Kogge-Stone prefix adder among NUM_REQ operand producers.
// The sum lands in a single-entry output register tagged with the granted requester index.
module prefix_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH:0]           res_sum,
  output logic [ID_W-1:0]          res_id,
  output logic [CNT_W-1:0]         op_count
);

  localparam int LVLS = $clog2(WIDTH);

  logic              res_valid_q, res_valid_d;
  logic [WIDTH:0]    res_sum_q, res_sum_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              out_free;
  logic              fire;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [WIDTH:0]    carry;
  logic [WIDTH:0]    sum;

  // Scan upward from rr_ptr; NUM_REQ is a power of two so the index wraps for free.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = rr_ptr_q + ID_W'(i);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while the block is held in reset.
  assign out_free  = !res_valid_q || res_ready;
  assign fire      = grant_found && out_free && rst_n;
  assign req_ready = fire ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

  assign op_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign op_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];

  // Kogge-Stone: level k combines generate/propagate spans of 2^(k-1) bits.
  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    if (k == 0) begin : g_base
      assign gg = op_a & op_b;
      assign pp = op_a ^ op_b;
    end else begin : g_step
      localparam int D = 1 << (k - 1);
      assign gg = g_lvl[k-1].gg | (g_lvl[k-1].pp & (g_lvl[k-1].gg << D));
      assign pp = g_lvl[k-1].pp & ((g_lvl[k-1].pp << D) | ({WIDTH{1'b1}} >> (WIDTH - D)));
    end
  end

  assign carry = {g_lvl[LVLS].gg, 1'b0};
  assign sum   = {carry[WIDTH], g_lvl[0].pp ^ carry[WIDTH-1:0]};

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    op_count_d  = op_count_q;
    if (fire) begin
      res_valid_d = 1'b1;
      res_sum_d   = sum;
      res_id_d    = grant_idx;
      rr_ptr_d    = grant_idx + 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    if (res_valid_q && res_ready && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
      op_count_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/prefix_adder_arbiter.md
Name: prefix_adder_arbiter

Overview:
- Shares one combinational WIDTH-bit prefix adder among NUM_REQ requesters.
- Each requester presents an operand pair with valid/ready. A round-robin arbiter grants at most one request per cycle.
- The sum is registered into a single-entry output stage with a requester tag, under downstream backpressure.
- Sits between operand producers and a result consumer in the adder test/benchmark fabric.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..16).
- WIDTH, 32, operand width; sum is WIDTH+1 bits.
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- res_valid  output  1  result register holds a valid sum.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH+1  A+B including carry-out.
- res_id  output  ID_W  index of the requester that produced res_sum.
- op_count  output  CNT_W  number of results accepted by the consumer, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, res_sum=0, res_id=0, rr_ptr=0, op_count=0. req_ready follows combinationally and is therefore 0.
- Reset mid-operation: any in-flight result is discarded; no partial state survives.
- out_free = !res_valid || res_ready.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, upward modulo NUM_REQ.
  - The first asserted index g is granted: req_ready[g] = out_free; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready = 0.
- req_ready may depend combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- Transfer fires when req_valid[g] && req_ready[g]. At the next rising edge:
  - res_sum <= {1'b0,A_g} + {1'b0,B_g}, full WIDTH+1-bit sum, no truncation.
  - res_id <= g; res_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly one cycle from accepted request to res_valid.
- Throughput: one result per cycle when res_ready is held high.
- Drain without refill: if res_valid && res_ready and no transfer fires, then res_valid <= 0. res_sum and res_id keep their old values.
- Simultaneous drain and refill in the same cycle: the new result replaces the old one with no bubble, and res_valid stays 1.
- Backpressure: while res_valid && !res_ready:
  - req_ready = 0.
  - res_sum, res_id and res_valid hold stable.
  - rr_ptr does not change.
- rr_ptr changes only on a transfer. An idle cycle or a stalled cycle leaves it unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- op_count increments on each cycle with res_valid && res_ready and saturates at all-ones. It does not wrap.
- Operands are sampled only in the transfer cycle; the requester may change A/B afterwards.
- Internal state is limited to rr_ptr, the output register and op_count. No other FSM is required.
- The adder function is A+B. The implementation may instantiate the team's prefix adder for WIDTH=32 and use a behavioural sum otherwise. The observable result must be identical in both cases.

Test Plan:
- Single request, carry-out: requester 0 presents A=0xFFFFFFFF, B=0x00000001 with res_ready=1. Required: req_ready=0001 that cycle; next cycle res_valid=1, res_sum=0x1_00000000, res_id=0.
- Full contention: all four requesters valid every cycle, res_ready=1, and requester i sends A=i, B=0x10. Required: grant order 0,1,2,3,0,1; one result per cycle; res_sum=0x10+id.
- Backpressure: hold res_ready=0 for 5 cycles while res_valid=1 with res_sum=0x000000005 and requesters 1 and 2 valid.
  - Required during the stall: req_ready=0 and the output stays stable.
  - Required on the release cycle: grant issued in the same cycle; the new result appears the next cycle with no bubble.
- Pointer skip: after a grant to requester 1 (rr_ptr=2), only requester 1 is valid. Required: requester 1 is granted again and rr_ptr returns to 2. Then with requesters 0 and 3 valid, requester 3 is granted first.
- Async reset mid-stream: assert rst_n=0 between clock edges while res_valid=1 and op_count=7. Required: res_valid=0, op_count=0 and req_ready=0 immediately; after release, the first grant goes to requester 0.
- Random regression: 100000 random operand pairs from random requesters with random res_ready. Check each res_sum == A+B (33 bits) for the tagged request, with no lost or duplicated transaction. op_count equals the accepted count, saturated at 0xFFFF.
